aes_mask_gen: RTL and testbench
===============================

# aes_mask_gen

Parametrised masking-stream generator for the AES datapath. It holds a secret mask key and, per block, runs a keyed multi-round XOR/rotate schedule to produce a mask word of WIDTH bits. The mask key evolves after every block. It sits beside the AES core, with the same init/next/ready handshake, and feeds masks to the core's masked datapath. Experimental: not a security claim until DPA analysis is done.

## Interface
- WIDTH, 128: block, key and mask width in bits; must be ≥ 16.
- ROUNDS_A, 10: rounds when keylen = 0.
- ROUNDS_B, 14: rounds when keylen = 1.
- ROT_A, 12: left-rotate per round when keylen = 0; must be < WIDTH.
- ROT_B, 9: left-rotate per round when keylen = 1; must be < WIDTH.
- clk  in  1  clock.
- reset_n  in  1  synchronous, active-low reset.
- init  in  1  load key and mode; sampled only when ready = 1.
- next  in  1  process block; sampled only when ready = 1.
- ready  out  1  idle and accepting commands.
- result_valid  out  1  result holds a completed mask.
- keylen  in  1  mode select; captured on init.
- key  in  WIDTH  mask key; captured on init.
- block  in  WIDTH  input block; captured on next.
- result  out  WIDTH  mask output; equals state_reg.

## Operation
- Registers:
  - key_reg: captured key.
  - rkey_reg: evolving round key.
  - state_reg
  - blk_reg: captured block.
  - mode_reg
  - round_ctr: width $clog2(max(ROUNDS_A, ROUNDS_B) + 1).
  - ctrl_reg, ready_reg, valid_reg.
- Values selected by mode_reg: R = mode_reg ? ROUNDS_B : ROUNDS_A, and ROT = mode_reg ? ROT_B : ROT_A.
- FSM states: IDLE, INIT, NEXT, FINAL.
- IDLE, init = 1:
  - key_reg and rkey_reg ← key; mode_reg ← keylen; valid_reg ← 0.
  - Go to INIT.
  - init has priority over next when both are high.
- IDLE, next = 1:
  - state_reg and blk_reg ← block; round_ctr ← 0; valid_reg ← 0.
  - Go to NEXT.
- INIT: go to IDLE; no datapath action.
- NEXT, each cycle:
  - state_reg ← state_reg ^ rkey_reg.
  - rkey_reg ← rotl(rkey_reg, ROT), with rotation mod WIDTH.
  - round_ctr++.
  - When round_ctr == R−1, go to FINAL.
- FINAL:
  - state_reg ← state_reg ^ blk_reg.
  - rkey_reg ← rkey_reg ^ key_reg.
  - valid_reg ← 1; go to IDLE.
- Result: the mask is the XOR of the R round keys rotl(K, i·ROT), i = 0..R−1. The block cancels out. K becomes rotl(K, R·ROT) ^ key_reg for the next block.
- ready_reg is 1 in IDLE and 0 in every other state. It is registered and changes with ctrl_reg.
- init or next while ready = 0: ignored, with no latching.
- key, block and keylen may change freely after the capture cycle.
- next before any init: operates on the reset key, which is 0. The result is 0.
- Illegal ctrl_reg encoding: go to IDLE.

## Timing
- Reset values: ready = 1, result_valid = 0, result = 0. All internal registers are 0 and ctrl_reg = IDLE.
- Reset asserted mid-operation: the next edge applies the reset values and the operation is abandoned.
- init sampled at edge T: ready = 0 during cycle T+1 and back to 1 at T+2.
- next sampled at edge T:
  - ready = 0 from T+1.
  - ready = 1 and result_valid = 1 at T+R+2: 12 cycles in mode A, 16 in mode B.
- result is stable from completion until the next accepted command. result_valid stays 1 until then.
- Back-to-back: a command may be accepted in the first cycle that ready = 1.

## Structure
- Package aes_mask_pkg holds:
  - the FSM state encodings (2 bits);
  - default round and rotate constants: 10/12 and 14/9;
  - a rotl function parametrised by width.
- One sub-module, aes_mask_keysched, owns key_reg, rkey_reg and mode_reg.
  - Inputs: load, step and final strobes.
  - Outputs: rkey and the R/ROT selection.
- Top level holds the FSM, round_ctr, state_reg and blk_reg.

## Test plan
- Reset, then no stimulus → ready = 1, result_valid = 0, result = 0. Repeat with reset asserted at NEXT round 5 → same values on the next cycle.
- init key = 0, then next block = 128'hDEADBEEF_… (any value) → result = 0 after exactly 12 cycles; ready low for cycles 1–11.
- init key = 128'h1, keylen = 0, then next block = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 → result = 128'h0000_1001_0010_0100_1001_0010_0100_1001.
- Follow-up next after the previous case → rkey before the block = bits 120 and 0 set. result matches the reference model of the key evolution.
- keylen = 1 with random key and block → ready returns high after 16 cycles. result matches the model using 14 rounds, rotate 9.
- Command rules:
  - init and next high together in IDLE → init wins; state_reg unchanged.
  - Pulse next while busy → ignored; the cycle count is unchanged.

Source files
------------

// File: rtl/aes_mask_pkg.sv
// aes_mask_pkg
// Shared definitions for the AES masking-stream generator:
//   - 2-bit control FSM encodings (IDLE/INIT/NEXT/FINAL)
//   - default round counts and per-round rotate amounts for both key modes
//   - rotl(): left rotate of the low 'width' bits of a ROTL_MAX_W-bit container
package aes_mask_pkg;

  localparam logic [1:0] CTRL_IDLE  = 2'd0;
  localparam logic [1:0] CTRL_INIT  = 2'd1;
  localparam logic [1:0] CTRL_NEXT  = 2'd2;
  localparam logic [1:0] CTRL_FINAL = 2'd3;

  localparam int unsigned DEF_WIDTH    = 128;
  localparam int unsigned DEF_ROUNDS_A = 10;
  localparam int unsigned DEF_ROUNDS_B = 14;
  localparam int unsigned DEF_ROT_A    = 12;
  localparam int unsigned DEF_ROT_B    = 9;

  // rotl() works on a fixed-size container so one function serves every
  // WIDTH up to this limit. Callers zero-extend into it and cast the result
  // back down. With constant width/amount it folds into plain wiring.
  localparam int unsigned ROTL_MAX_W = 1024;

  function automatic logic [ROTL_MAX_W-1:0] rotl(
    input logic [ROTL_MAX_W-1:0] value,
    input int unsigned           width,
    input int unsigned           amount
  );
    logic [ROTL_MAX_W-1:0] rotated;
    int unsigned           shift;
    logic [9:0]            src;
    rotated = '0;
    shift   = amount % width;
    for (int unsigned i = 0; i < ROTL_MAX_W; i++) begin
      if (i < width) begin
        src = (i >= shift) ? 10'(i - shift) : 10'(i + width - shift);
        rotated[i] = value[src];
      end
    end
    return rotated;
  endfunction

endpackage

// File: rtl/aes_mask_keysched.sv
// aes_mask_keysched
// Holds the captured mask key, the evolving round key and the key mode.
// Ports:
//   clk, reset_n      clock, synchronous active-low reset
//   i_load            capture i_key into key and round key, i_keylen into mode
//   i_keylen, i_key   mode select and key to capture
//   i_step            advance round key by one rotate
//   i_final           fold the captured key back into the round key
//   o_rkey            current round key
//   o_rounds          round count selected by the captured mode
module aes_mask_keysched import aes_mask_pkg::*; #(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned ROUNDS_A = DEF_ROUNDS_A,
  parameter int unsigned ROUNDS_B = DEF_ROUNDS_B,
  parameter int unsigned ROT_A    = DEF_ROT_A,
  parameter int unsigned ROT_B    = DEF_ROT_B,
  parameter int unsigned CTR_W    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_keylen,
  input  logic [WIDTH-1:0] i_key,
  input  logic             i_step,
  input  logic             i_final,
  output logic [WIDTH-1:0] o_rkey,
  output logic [CTR_W-1:0] o_rounds
);

  logic [WIDTH-1:0] r_key;
  logic [WIDTH-1:0] r_rkey;
  logic             r_mode;

  logic [WIDTH-1:0] w_rotA;
  logic [WIDTH-1:0] w_rotB;
  logic [WIDTH-1:0] w_rotNext;

  // Both rotations are built with constant amounts and then muxed, which
  // keeps each one a pure rewiring instead of a variable barrel shifter.
  assign w_rotA    = WIDTH'(rotl(ROTL_MAX_W'(r_rkey), WIDTH, ROT_A));
  assign w_rotB    = WIDTH'(rotl(ROTL_MAX_W'(r_rkey), WIDTH, ROT_B));
  assign w_rotNext = r_mode ? w_rotB : w_rotA;

  assign o_rkey   = r_rkey;
  assign o_rounds = r_mode ? CTR_W'(ROUNDS_B) : CTR_W'(ROUNDS_A);

  // The strobes come from mutually exclusive FSM states; the priority
  // order here only matters for documentation.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_key  <= '0;
      r_rkey <= '0;
      r_mode <= 1'b0;
    end else if (i_load) begin
      r_key  <= i_key;
      r_rkey <= i_key;
      r_mode <= i_keylen;
    end else if (i_step) begin
      r_rkey <= w_rotNext;
    end else if (i_final) begin
      r_rkey <= r_rkey ^ r_key;
    end
  end

endmodule

// File: rtl/aes_mask_gen.sv
// aes_mask_gen
// Masking-stream generator that sits beside the AES core and shares its
// init/next/ready handshake. Each block runs R rounds of state ^= round key
// with the round key rotated every round, then a final block XOR that cancels
// the block out. The round key evolves across blocks. Experimental: not a
// security claim.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   i_init                load key/mode (honoured only while o_ready)
//   i_next                process a block (honoured only while o_ready)
//   i_keylen, i_key       mode select and mask key, captured on init
//   i_block               input block, captured on next
//   o_ready               idle and accepting commands
//   o_resultValid         o_result holds a completed mask
//   o_result              mask output (the state register)
module aes_mask_gen import aes_mask_pkg::*; #(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned ROUNDS_A = DEF_ROUNDS_A,
  parameter int unsigned ROUNDS_B = DEF_ROUNDS_B,
  parameter int unsigned ROT_A    = DEF_ROT_A,
  parameter int unsigned ROT_B    = DEF_ROT_B
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_init,
  input  logic             i_next,
  output logic             o_ready,
  output logic             o_resultValid,
  input  logic             i_keylen,
  input  logic [WIDTH-1:0] i_key,
  input  logic [WIDTH-1:0] i_block,
  output logic [WIDTH-1:0] o_result
);

  localparam int unsigned MAX_ROUNDS = (ROUNDS_A > ROUNDS_B) ? ROUNDS_A : ROUNDS_B;
  localparam int unsigned CTR_W      = $clog2(MAX_ROUNDS + 1);

  logic [1:0]       r_ctrl;
  logic             r_ready;
  logic             r_valid;
  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_blk;
  logic [CTR_W-1:0] r_roundCtr;

  logic             w_load;
  logic             w_step;
  logic             w_final;
  logic [WIDTH-1:0] w_rkey;
  logic [CTR_W-1:0] w_rounds;
  logic             w_lastRound;

  // init wins over next when both arrive together in IDLE
  assign w_load      = (r_ctrl == CTRL_IDLE) && i_init;
  assign w_step      = (r_ctrl == CTRL_NEXT);
  assign w_final     = (r_ctrl == CTRL_FINAL);
  assign w_lastRound = (r_roundCtr == (w_rounds - CTR_W'(1)));

  aes_mask_keysched #(
    .WIDTH    (WIDTH),
    .ROUNDS_A (ROUNDS_A),
    .ROUNDS_B (ROUNDS_B),
    .ROT_A    (ROT_A),
    .ROT_B    (ROT_B),
    .CTR_W    (CTR_W)
  ) u_keysched (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_load   (w_load),
    .i_keylen (i_keylen),
    .i_key    (i_key),
    .i_step   (w_step),
    .i_final  (w_final),
    .o_rkey   (w_rkey),
    .o_rounds (w_rounds)
  );

  // ready is registered alongside the state so it is high exactly when the
  // next state is IDLE; commands outside IDLE are simply not looked at.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ctrl     <= CTRL_IDLE;
      r_ready    <= 1'b1;
      r_valid    <= 1'b0;
      r_state    <= '0;
      r_blk      <= '0;
      r_roundCtr <= '0;
    end else begin
      case (r_ctrl)
        CTRL_IDLE: begin
          if (i_init) begin
            r_valid <= 1'b0;
            r_ready <= 1'b0;
            r_ctrl  <= CTRL_INIT;
          end else if (i_next) begin
            r_state    <= i_block;
            r_blk      <= i_block;
            r_roundCtr <= '0;
            r_valid    <= 1'b0;
            r_ready    <= 1'b0;
            r_ctrl     <= CTRL_NEXT;
          end
        end
        CTRL_INIT: begin
          r_ready <= 1'b1;
          r_ctrl  <= CTRL_IDLE;
        end
        CTRL_NEXT: begin
          r_state    <= r_state ^ w_rkey;
          r_roundCtr <= r_roundCtr + CTR_W'(1);
          if (w_lastRound) begin
            r_ctrl <= CTRL_FINAL;
          end
        end
        CTRL_FINAL: begin
          // state already holds block ^ (XOR of round keys); this strips the block
          r_state <= r_state ^ r_blk;
          r_valid <= 1'b1;
          r_ready <= 1'b1;
          r_ctrl  <= CTRL_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_ctrl  <= CTRL_IDLE;
        end
      endcase
    end
  end

  assign o_ready       = r_ready;
  assign o_resultValid = r_valid;
  assign o_result      = r_state;

endmodule

// File: tb/tb_aes_mask_gen.sv
// tb_aes_mask_gen
// Self-checking bench for aes_mask_gen (default parameters). A table of
// init/next vectors is filled up front from a closed-form reference model
// (mask = XOR of rotl(K, i*ROT) for i < R; K' = rotl(K, R*ROT) ^ key),
// then applied in order. Hand sequences cover reset, command collisions,
// commands while busy and reset in the middle of a block.
module tb_aes_mask_gen;

  localparam int W    = 128;
  localparam int NVEC = 8;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_init;
  logic         i_next;
  logic         i_keylen;
  logic [W-1:0] i_key;
  logic [W-1:0] i_block;
  logic         o_ready;
  logic         o_resultValid;
  logic [W-1:0] o_result;

  int vectors     = 0;
  int miscompares = 0;

  // reference model state
  logic [W-1:0] mK;
  logic [W-1:0] mKey;
  logic         mMode;
  logic [W-1:0] mResult;

  typedef struct {
    logic         doInit;
    logic         keylen;
    logic [W-1:0] key;
    logic [W-1:0] block;
    logic [W-1:0] expResult;
    int           expCycles;
  } vec_t;

  vec_t vecs[NVEC];

  aes_mask_gen dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .i_init        (i_init),
    .i_next        (i_next),
    .o_ready       (o_ready),
    .o_resultValid (o_resultValid),
    .i_keylen      (i_keylen),
    .i_key         (i_key),
    .i_block       (i_block),
    .o_result      (o_result)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [W-1:0] rotlModel(input logic [W-1:0] v, input int n);
    logic [2*W-1:0] d;
    d = {v, v} << (n % W);
    return d[2*W-1:W];
  endfunction

  task automatic modelReset();
    mK      = '0;
    mKey    = '0;
    mMode   = 1'b0;
    mResult = '0;
  endtask

  task automatic modelInit(input logic [W-1:0] key, input logic keylen);
    mKey  = key;
    mK    = key;
    mMode = keylen;
  endtask

  task automatic modelNext(output logic [W-1:0] mask, output int cycles);
    int r;
    int rot;
    r    = mMode ? 14 : 10;
    rot  = mMode ? 9 : 12;
    mask = '0;
    for (int i = 0; i < r; i++) mask ^= rotlModel(mK, i * rot);
    mK      = rotlModel(mK, r * rot) ^ mKey;
    mResult = mask;
    cycles  = r + 2;
  endtask

  task automatic addVec(input int idx, input logic doInit, input logic keylen,
                        input logic [W-1:0] key, input logic [W-1:0] block);
    logic [W-1:0] mask;
    int           cyc;
    if (doInit) modelInit(key, keylen);
    modelNext(mask, cyc);
    vecs[idx].doInit    = doInit;
    vecs[idx].keylen    = keylen;
    vecs[idx].key       = key;
    vecs[idx].block     = block;
    vecs[idx].expResult = mask;
    vecs[idx].expCycles = cyc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic waitReady(inout int cycles);
    while (o_ready !== 1'b1 && cycles < 64) begin
      tick();
      cycles++;
    end
  endtask

  // init (optional) followed by next; returns edges from the next edge until ready
  task automatic applyStimulus(input vec_t v, input int idx, output int cycles);
    if (v.doInit) begin
      i_key    = v.key;
      i_keylen = v.keylen;
      i_init   = 1'b1;
      tick();
      i_init   = 1'b0;
      i_key    = rand128();
      i_keylen = ~v.keylen;
      checkOutput($sformatf("vec%0d init ready low", idx), W'(o_ready), W'(0));
      tick();
      checkOutput($sformatf("vec%0d init ready back", idx), W'(o_ready), W'(1));
    end
    i_block = v.block;
    i_next  = 1'b1;
    tick();
    i_next  = 1'b0;
    i_block = rand128();
    cycles  = 1;
    checkOutput($sformatf("vec%0d busy", idx), W'(o_ready), W'(0));
    waitReady(cycles);
  endtask

  initial begin
    logic [W-1:0] expMask;
    logic [W-1:0] prevResult;
    int           expCyc;
    int           cycles;

    reset_n  = 1'b0;
    i_init   = 1'b0;
    i_next   = 1'b0;
    i_keylen = 1'b0;
    i_key    = '0;
    i_block  = '0;

    // vector table, expected values from the model in application order
    modelReset();
    addVec(0, 1'b1, 1'b0, '0, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
    vecs[0].expResult = '0;
    addVec(1, 1'b1, 1'b0, 128'h1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    vecs[1].expResult = 128'h0000_1001_0010_0100_1001_0010_0100_1001;
    addVec(2, 1'b0, 1'b0, '0, rand128());
    addVec(3, 1'b1, 1'b1, rand128(), rand128());
    for (int i = 4; i < NVEC; i++) begin
      addVec(i, (i == 4) ? 1'b1 : 1'(($urandom_range(0, 1))), 1'($urandom_range(0, 1)),
             rand128(), rand128());
    end

    // reset state
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    checkOutput("reset ready", W'(o_ready), W'(1));
    checkOutput("reset valid", W'(o_resultValid), W'(0));
    checkOutput("reset result", o_result, '0);

    for (int v = 0; v < NVEC; v++) begin
      applyStimulus(vecs[v], v, cycles);
      checkOutput($sformatf("vec%0d cycles", v), W'(cycles), W'(vecs[v].expCycles));
      checkOutput($sformatf("vec%0d result", v), o_result, vecs[v].expResult);
      checkOutput($sformatf("vec%0d valid", v), W'(o_resultValid), W'(1));
    end

    // result and valid hold while idle
    tick();
    tick();
    tick();
    checkOutput("hold result", o_result, mResult);
    checkOutput("hold valid", W'(o_resultValid), W'(1));

    // init and next together: init wins, state untouched
    prevResult = mResult;
    i_key      = rand128();
    i_keylen   = 1'b0;
    i_block    = rand128();
    i_init     = 1'b1;
    i_next     = 1'b1;
    modelInit(i_key, 1'b0);
    tick();
    i_init = 1'b0;
    i_next = 1'b0;
    checkOutput("both ready low", W'(o_ready), W'(0));
    checkOutput("both state kept", o_result, prevResult);
    checkOutput("both valid clr", W'(o_resultValid), W'(0));
    tick();
    checkOutput("both ready back", W'(o_ready), W'(1));
    checkOutput("both state still", o_result, prevResult);

    // commands while busy are ignored
    modelNext(expMask, expCyc);
    i_block = rand128();
    i_next  = 1'b1;
    tick();
    i_next  = 1'b0;
    cycles  = 1;
    tick();
    tick();
    cycles += 2;
    i_block = rand128();
    i_key   = rand128();
    i_next  = 1'b1;
    i_init  = 1'b1;
    tick();
    cycles++;
    i_next  = 1'b0;
    i_init  = 1'b0;
    waitReady(cycles);
    checkOutput("busy cycles", W'(cycles), W'(expCyc));
    checkOutput("busy result", o_result, expMask);
    checkOutput("busy valid", W'(o_resultValid), W'(1));

    // reset at NEXT round 5
    i_key    = rand128();
    i_keylen = 1'b0;
    i_init   = 1'b1;
    tick();
    i_init = 1'b0;
    tick();
    i_block = rand128();
    i_next  = 1'b1;
    tick();
    i_next = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset_n = 1'b0;
    tick();
    checkOutput("midreset ready", W'(o_ready), W'(1));
    checkOutput("midreset valid", W'(o_resultValid), W'(0));
    checkOutput("midreset result", o_result, '0);
    reset_n = 1'b1;
    modelReset();

    // next on the reset key gives zero
    modelNext(expMask, expCyc);
    i_block = rand128();
    i_next  = 1'b1;
    tick();
    i_next = 1'b0;
    cycles = 1;
    waitReady(cycles);
    checkOutput("postreset cycles", W'(cycles), W'(expCyc));
    checkOutput("postreset result", o_result, expMask);
    checkOutput("postreset valid", W'(o_resultValid), W'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
